// File: rtl/lcb_pkg.sv
// Shared definitions for the LCB word packer: FSM state encoding, the header
// nibble that marks the high byte of a word, and default bank/timeout sizes.
package lcb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    localparam logic [3:0]  HDR_NIBBLE  = 4'h5;
    localparam logic [10:0] WORDS_DEF   = 11'd1024;
    localparam logic [15:0] TIMEOUT_DEF = 16'd800;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module bit_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcb_word_packer.sv
// Packs UART byte pairs (header nibble + low byte) into 12-bit words and
// writes them sequentially into a bank; the Orbita frame domain swaps banks
// by toggling SW, which restarts the write address.
//
// state | meaning
// IDLE  | waiting for a header byte (upper nibble 5)
// HIGH  | header nibble held, waiting for the low byte or timeout
// WRITE | one-cycle write strobe with word and address stable
// FULL  | bank holds WORDS words, bytes dropped until SW toggles
module lcb_word_packer
    import lcb_pkg::*;
#(
    parameter logic [10:0] WORDS   = WORDS_DEF,
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  iData,
    input  logic        strob,
    input  logic        SW,
    output logic [11:0] orbWord,
    output logic        WE,
    output logic [10:0] WrAddr,
    output logic        full,
    output logic [7:0]  errCnt,
    output logic        test
);

    state_t      state;
    state_t      state_nxt;
    logic        sw_sync;
    logic        sw_prev;
    logic [1:0]  sync_fill;
    logic        toggle;
    logic [3:0]  hi_nib;
    logic [15:0] timer;
    logic        err_evt;
    logic        hdr_ok;
    logic        last_addr;
    logic        timed_out;

    bit_sync2 u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (SW),
        .q   (sw_sync)
    );

    // Edge detect on the synchronized SW; sync_fill holds detection off until
    // the synchronizer has flushed its reset value, so the first real SW level
    // after reset never reads as a toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_prev   <= 1'b0;
            sync_fill <= 2'd0;
        end else begin
            sw_prev <= sw_sync;
            if (sync_fill != 2'd3) begin
                sync_fill <= sync_fill + 2'd1;
            end
        end
    end

    assign toggle    = (sync_fill == 2'd3) && (sw_sync != sw_prev);
    assign hdr_ok    = (iData[7:4] == HDR_NIBBLE);
    assign last_addr = (WrAddr == WORDS - 11'd1);
    assign timed_out = (timer == TIMEOUT);

    // Next-state and error-event decode; a bank toggle overrides everything
    // and silently swallows any coincident byte.
    always_comb begin
        state_nxt = state;
        err_evt   = 1'b0;
        if (toggle) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (strob) begin
                        if (hdr_ok) state_nxt = ST_HIGH;
                        else        err_evt   = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (strob) begin
                        state_nxt = ST_WRITE;
                    end else if (timed_out) begin
                        state_nxt = ST_IDLE;
                        err_evt   = 1'b1;
                    end
                end
                ST_WRITE: state_nxt = last_addr ? ST_FULL : ST_IDLE;
                ST_FULL: begin
                    if (strob) err_evt = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register plus the header nibble and inter-byte timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            hi_nib <= 4'h0;
            timer  <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && strob && hdr_ok) begin
                hi_nib <= iData[3:0];
                timer  <= 16'd0;
            end else if (state == ST_HIGH) begin
                timer <= timer + 16'd1;
            end
        end
    end

    // Word assembly and write address; a toggle during WRITE lets the
    // current strobe finish at the old address and then restarts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            orbWord <= 12'h000;
            WrAddr  <= 11'd0;
        end else begin
            if (state == ST_HIGH && strob && !toggle) begin
                orbWord <= {hi_nib, iData};
            end
            if (toggle) begin
                WrAddr <= 11'd0;
            end else if (state == ST_WRITE && !last_addr) begin
                WrAddr <= WrAddr + 11'd1;
            end
        end
    end

    // Saturating error counter with a pulse on every event, saturated or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errCnt <= 8'h00;
            test   <= 1'b0;
        end else begin
            test <= err_evt;
            if (err_evt) begin
                errCnt <= sat_inc8(errCnt);
            end
        end
    end

    assign WE   = (state == ST_WRITE);
    assign full = (state == ST_FULL);

endmodule

// File: tb/tb_lcb_word_packer.sv
// Bench for lcb_word_packer: directed scenarios plus randomized byte traffic,
// checked by a scoreboard fed from a per-edge behavioural model.
module tb_lcb_word_packer;
    timeunit 1ns;
    timeprecision 10ps;

    localparam logic [10:0] WORDS = 11'd4;
    localparam int          TMO   = 800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  iData = 8'h00;
    logic        strob = 1'b0;
    logic        SW = 1'b0;
    logic [11:0] orbWord;
    logic        WE;
    logic [10:0] WrAddr;
    logic        full;
    logic [7:0]  errCnt;
    logic        test;

    lcb_word_packer #(.WORDS(WORDS), .TIMEOUT(16'(TMO))) dut (
        .clk     (clk),
        .rst     (rst),
        .iData   (iData),
        .strob   (strob),
        .SW      (SW),
        .orbWord (orbWord),
        .WE      (WE),
        .WrAddr  (WrAddr),
        .full    (full),
        .errCnt  (errCnt),
        .test    (test)
    );

    always #6.25 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [22:0] exp_wr[$];
    logic [7:0]  exp_err[$];

    bit         m_pend;
    logic [3:0] m_nib;
    int         m_hdr_edge;
    int         m_addr;
    bit         m_full;
    bit         m_writing;
    int         m_err;
    int         edge_n;
    bit         swh[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
        exp_err.push_back(8'(m_err));
    endtask

    task automatic reset_model();
        m_pend = 0; m_nib = 4'h0; m_hdr_edge = 0; m_addr = 0;
        m_full = 0; m_writing = 0; m_err = 0; edge_n = 0;
        swh.delete();
        swh.push_back(1'b0);
    endtask

    // Behaviour for the upcoming clock edge given the inputs now applied.
    // SW is seen two edges late; a change in that delayed view restarts the bank.
    task automatic model_edge();
        bit tog;
        if (!rst) return;
        edge_n++;
        swh.push_back(SW);
        tog = (edge_n >= 4) && (swh[edge_n-2] != swh[edge_n-3]);
        if (tog) begin
            m_pend = 0; m_addr = 0; m_full = 0; m_writing = 0;
        end else if (m_writing) begin
            m_writing = 0;
            if (m_addr == int'(WORDS) - 1) m_full = 1;
            else m_addr++;
        end else if (m_full) begin
            if (strob) model_err();
        end else if (m_pend) begin
            if (strob) begin
                exp_wr.push_back({11'(m_addr), m_nib, iData});
                m_writing = 1;
                m_pend = 0;
            end else if (edge_n - m_hdr_edge == TMO + 1) begin
                model_err();
                m_pend = 0;
            end
        end else if (strob) begin
            if (iData[7:4] == 4'h5) begin
                m_pend = 1; m_nib = iData[3:0]; m_hdr_edge = edge_n;
            end else begin
                model_err();
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        strob = 1'b1;
        iData = b;
        tick();
        strob = 1'b0;
    endtask

    // Scoreboard monitor: every write strobe and error pulse is matched
    // against the oldest expectation.
    always @(negedge clk) begin
        logic [22:0] e;
        logic [7:0]  c;
        if (WE) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL we_unexpected: got word %0h addr %0h expected no write", orbWord, WrAddr);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_word", 32'(orbWord), 32'(e[11:0]));
                chk("wr_addr", 32'(WrAddr), 32'(e[22:12]));
            end
        end
        if (test) begin
            if (exp_err.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL test_unexpected: got errCnt %0h expected no error pulse", errCnt);
            end else begin
                c = exp_err.pop_front();
                chk("err_cnt", 32'(errCnt), 32'(c));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(WE), 0);
        chk({tag, "_word"},  32'(orbWord), 0);
        chk({tag, "_addr"},  32'(WrAddr), 0);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_err"},   32'(errCnt), 0);
        chk({tag, "_test"},  32'(test), 0);
    endtask

    initial begin
        int r;
        reset_model();
        idle(3);
        chk_all_zero("rst");
        rst = 1'b1;
        reset_model();

        // basic pair, latency and address step
        send(8'h5A); idle(2); send(8'h3C);
        chk("lat_we", 32'(WE), 1);
        chk("lat_word", 32'(orbWord), 32'h A3C);
        chk("lat_addr", 32'(WrAddr), 0);
        tick();
        chk("we_once", 32'(WE), 0);
        chk("addr_inc", 32'(WrAddr), 1);

        // bad header
        idle(2); send(8'h7A);
        chk("bad_test", 32'(test), 1);
        chk("bad_cnt", 32'(errCnt), 1);
        tick();
        chk("test_once", 32'(test), 0);

        // timeout, then a good pair, then a low byte on the last allowed cycle
        send(8'h51); idle(805);
        chk("tmo_cnt", 32'(errCnt), 2);
        send(8'h52); idle(2); send(8'h00);
        chk("tmo_we", 32'(WE), 1);
        chk("tmo_word", 32'(orbWord), 32'h200);
        idle(2);
        send(8'h53); idle(TMO); send(8'h44);
        chk("edge_we", 32'(WE), 1);
        chk("edge_word", 32'(orbWord), 32'h344);
        chk("edge_cnt", 32'(errCnt), 2);
        idle(2);

        // bank fill and release
        SW = 1'b1; idle(3);
        chk("tog_addr", 32'(WrAddr), 0);
        for (int i = 0; i < 4; i++) begin
            send(8'h50 | 8'(i)); idle(1);
            send(8'($urandom_range(0, 255))); idle(1);
        end
        chk("full_set", 32'(full), 1);
        chk("full_addr", 32'(WrAddr), 3);
        send(8'h5F);
        chk("full_no_we", 32'(WE), 0);
        chk("full_err", 32'(errCnt), 3);
        idle(2);
        SW = 1'b0; idle(2);
        chk("full_hold", 32'(full), 1);
        tick();
        chk("full_clr", 32'(full), 0);
        chk("addr_clr", 32'(WrAddr), 0);

        // toggle landing on the WRITE cycle
        send(8'h5E); idle(1); send(8'h11); idle(2);
        send(8'h56); idle(1);
        SW = 1'b1; tick();
        send(8'h77);
        chk("tw_we", 32'(WE), 1);
        chk("tw_addr", 32'(WrAddr), 1);
        chk("tw_word", 32'(orbWord), 32'h677);
        tick();
        chk("tw_addr0", 32'(WrAddr), 0);

        // toggle coinciding with a byte drops it silently
        idle(3);
        SW = 1'b0; idle(2);
        send(8'h7E);
        chk("ts_test", 32'(test), 0);
        chk("ts_cnt", 32'(errCnt), 3);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                SW = ~SW; idle(4);
            end else if (r < 10) begin
                idle(TMO + 2 + int'($urandom_range(0, 2)));
            end else begin
                if ($urandom_range(0, 99) < 55) send({4'h5, 4'($urandom_range(0, 15))});
                else send(8'($urandom_range(0, 255)));
                idle(int'($urandom_range(1, 3)));
            end
        end

        // saturation
        SW = ~SW; idle(4);
        for (int i = 0; i < 260; i++) begin
            send(8'h60 | 8'($urandom_range(0, 15))); idle(1);
        end
        chk("sat_cnt", 32'(errCnt), 32'hFF);

        // reset while a pair is half-assembled, SW high across reset
        send(8'h55); idle(2);
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        SW = 1'b1;
        idle(3);
        chk("abort_we", 32'(WE), 0);
        chk("abort_cnt", 32'(errCnt), 0);
        rst = 1'b1;
        reset_model();
        idle(1); send(8'h5B); idle(1); send(8'h12);
        chk("pr_we", 32'(WE), 1);
        chk("pr_word", 32'(orbWord), 32'hB12);
        chk("pr_addr", 32'(WrAddr), 0);

        idle(4);
        chk("wr_left", 32'(exp_wr.size()), 0);
        chk("err_left", 32'(exp_err.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
